viterbi_decoder: RTL

- Hard-decision Viterbi decoder for the 802.11a K=7 convolutional code (g0=133o "A", g1=171o "B"); the receive-side counterpart of the transmit encoder.
- Accepts the serial, possibly punctured coded bit stream (rate 1/2, 2/3 or 3/4) and depunctures it with erasures.
- Runs a 64-state add-compare-select step per coded pair, with register-exchange survivors, and emits decoded data bits serially to the descrambler.

---
 rtl/viterbi_decoder_if.sv | 23 ++
 rtl/viterbi_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_decoder_if.sv
// Streaming bus of the Viterbi decoder: coded-bit input side and decoded-bit output side.
interface viterbi_decoder_if;
    logic [1:0] rate;
    logic       in_bit;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_last;

    // Source of coded bits, sink of decoded bits
    modport master (
        output rate, in_bit, in_valid, in_last,
        input  in_ready, out_bit, out_valid, out_last
    );

    // Decoder side
    modport slave (
        input  rate, in_bit, in_valid, in_last,
        output in_ready, out_bit, out_valid, out_last
    );
endinterface

// File: rtl/viterbi_decoder.sv
// Hard-decision K=7 (133o/171o) Viterbi decoder with depuncturing (1/2, 2/3, 3/4),
// 64-state ACS, register-exchange survivors and terminated-trellis flush.
module viterbi_decoder #(
    parameter int unsigned TB_DEPTH = 36,
    parameter int unsigned PM_W     = 8
) (
    input logic              Clk,
    input logic              reset,
    viterbi_decoder_if.slave bus
);
    localparam int unsigned     NS       = 64;
    localparam int unsigned     FILL_W   = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0] PM_INIT  = {2'b01, {(PM_W-2){1'b0}}};
    localparam logic [PM_W-1:0] PM_MASK  = {1'b0, {(PM_W-1){1'b1}}};
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e              r_state, w_state_d;
    logic [1:0]          r_rate, w_rate_eff;
    logic [1:0]          r_phase, w_phase_d, w_phase_max;
    logic                r_hold_a;
    logic                r_pa, r_pb, r_ea, r_eb;
    logic                r_pair_valid, r_pair_last;
    logic                w_pa, w_pb, w_ea, w_eb, w_pair_done;
    logic                w_accept, w_acs_en, w_flush_emit, w_flush_done, w_in_ready;
    logic [PM_W-1:0]     r_pm [NS];
    logic [TB_DEPTH-1:0] r_surv [NS];
    logic [PM_W-1:0]     w_pm_acs [NS];
    logic [TB_DEPTH-1:0] w_surv_acs [NS];
    logic [NS-1:0]       w_msb;
    logic                w_norm;
    logic [FILL_W-1:0]   r_fill, w_fill_idx;
    logic [5:0]          w_min_idx;
    logic [PM_W-1:0]     w_min_pm;
    logic                r_out_bit, r_out_valid, r_out_last;

    // Hamming distance between received pair and the branch label; erased bits count 0
    function automatic logic [1:0] f_bm(input logic [5:0] s, input logic u,
                                        input logic ra, input logic rb,
                                        input logic ea, input logic eb);
        logic exp_a, exp_b;
        exp_a = u ^ s[1] ^ s[2] ^ s[4] ^ s[5];
        exp_b = u ^ s[0] ^ s[1] ^ s[2] ^ s[5];
        return {1'b0, ~ea & (exp_a ^ ra)} + {1'b0, ~eb & (exp_b ^ rb)};
    endfunction

    // FSM state register
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) r_state <= StIdle;
        else        r_state <= w_state_d;
    end

    // FSM next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StRun;
            StRun:   if (r_pair_valid && r_pair_last) w_state_d = StFlush;
            StFlush: if (r_fill <= FILL_ONE) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath strobes
    always_comb begin
        w_in_ready   = (r_state != StFlush);
        w_acs_en     = (r_state == StRun) && r_pair_valid;
        w_flush_emit = (r_state == StFlush) && (r_fill != '0);
        w_flush_done = (r_state == StFlush) && (r_fill <= FILL_ONE);
    end

    // Once the last bit is taken, nothing more enters until the flush completes
    assign w_accept   = bus.in_valid && w_in_ready && !r_pair_last;
    assign w_fill_idx = r_fill - FILL_ONE;

    // Depuncture: map the current phase to an (A,B) pair with erasure flags
    always_comb begin
        w_rate_eff = (r_state == StIdle) ? bus.rate : r_rate;
        case (w_rate_eff)
            2'd1:    w_phase_max = 2'd2;
            2'd2:    w_phase_max = 2'd3;
            default: w_phase_max = 2'd1;
        endcase
        w_pa        = bus.in_bit;
        w_pb        = 1'b0;
        w_ea        = 1'b0;
        w_eb        = 1'b0;
        w_pair_done = 1'b0;
        unique case (r_phase)
            2'd0: begin
                // A lone final A bit closes the pair with an erased B
                if (bus.in_last) begin
                    w_pair_done = 1'b1;
                    w_eb        = 1'b1;
                end
            end
            2'd1: begin
                w_pa        = r_hold_a;
                w_pb        = bus.in_bit;
                w_pair_done = 1'b1;
            end
            2'd2: begin
                w_eb        = 1'b1;
                w_pair_done = 1'b1;
            end
            default: begin
                w_pa        = 1'b0;
                w_ea        = 1'b1;
                w_pb        = bus.in_bit;
                w_pair_done = 1'b1;
            end
        endcase
        w_phase_d = (bus.in_last || r_phase == w_phase_max) ? 2'd0 : r_phase + 2'd1;
    end

    // Depuncture state: phase, held A bit, completed pair and latched rate
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_phase      <= '0;
            r_hold_a     <= 1'b0;
            r_rate       <= '0;
            r_pa         <= 1'b0;
            r_pb         <= 1'b0;
            r_ea         <= 1'b0;
            r_eb         <= 1'b0;
            r_pair_valid <= 1'b0;
            r_pair_last  <= 1'b0;
        end else if (w_flush_done) begin
            r_phase      <= '0;
            r_pair_valid <= 1'b0;
            r_pair_last  <= 1'b0;
        end else begin
            r_pair_valid <= w_accept && w_pair_done;
            r_pair_last  <= w_accept && bus.in_last;
            if (w_accept) begin
                r_phase <= w_phase_d;
                if (r_phase == 2'd0) r_hold_a <= bus.in_bit;
                if (r_state == StIdle) r_rate <= bus.rate;
                if (w_pair_done) begin
                    r_pa <= w_pa;
                    r_pb <= w_pb;
                    r_ea <= w_ea;
                    r_eb <= w_eb;
                end
            end
        end
    end

    // Add-compare-select per state; predecessors {0,n[5:1]} and {1,n[5:1]}, input u = n[0]
    for (genvar g = 0; g < NS; g++) begin : g_acs
        localparam logic [5:0] P0 = 6'(g / 2);
        localparam logic [5:0] P1 = 6'(g / 2 + 32);
        localparam logic       U  = 1'(g % 2);
        logic [PM_W-1:0]     w_c0, w_c1;
        logic                w_sel;
        logic [TB_DEPTH-1:0] w_sp;
        assign w_c0 = r_pm[P0] + PM_W'(f_bm(P0, U, r_pa, r_pb, r_ea, r_eb));
        assign w_c1 = r_pm[P1] + PM_W'(f_bm(P1, U, r_pa, r_pb, r_ea, r_eb));
        // Ties keep the x=0 predecessor
        assign w_sel         = (w_c1 < w_c0);
        assign w_sp          = w_sel ? r_surv[P1] : r_surv[P0];
        assign w_pm_acs[g]   = w_sel ? w_c1 : w_c0;
        assign w_surv_acs[g] = {w_sp[TB_DEPTH-2:0], U};
        assign w_msb[g]      = w_pm_acs[g][PM_W-1];
    end

    assign w_norm = &w_msb;

    // Minimum current metric, lowest index wins ties
    always_comb begin
        w_min_idx = '0;
        w_min_pm  = r_pm[0];
        for (int n = 1; n < NS; n++) begin
            if (r_pm[n] < w_min_pm) begin
                w_min_pm  = r_pm[n];
                w_min_idx = 6'(n);
            end
        end
    end

    // Trellis state: metrics, survivors and fill counter
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NS; n++) begin
                r_pm[n]   <= (n == 0) ? '0 : PM_INIT;
                r_surv[n] <= '0;
            end
            r_fill <= '0;
        end else if (w_flush_done) begin
            for (int n = 0; n < NS; n++) begin
                r_pm[n]   <= (n == 0) ? '0 : PM_INIT;
                r_surv[n] <= '0;
            end
            r_fill <= '0;
        end else if (w_acs_en) begin
            for (int n = 0; n < NS; n++) begin
                r_pm[n]   <= w_norm ? (w_pm_acs[n] & PM_MASK) : w_pm_acs[n];
                r_surv[n] <= w_surv_acs[n];
            end
            if (r_fill != FILL_MAX) r_fill <= r_fill + FILL_ONE;
        end else if (w_flush_emit) begin
            r_fill <= r_fill - FILL_ONE;
        end
    end

    // Output register: the bit about to leave the window in RUN, state-0 survivor in FLUSH
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= (w_acs_en && r_fill == FILL_MAX) || w_flush_emit;
            r_out_bit   <= w_flush_emit ? r_surv[0][w_fill_idx]
                                        : r_surv[w_min_idx][TB_DEPTH-1];
            r_out_last  <= w_flush_emit && (r_fill == FILL_ONE);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_bit   = r_out_bit;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
endmodule
